// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift unit.
// Contents:
//   state_t     - sequencer FSM states (IDLE, SHIFT, DONE)
//   DIR_LEFT    - dir encoding for a left shift
//   DIR_RIGHT   - dir encoding for a right shift
//   SHIFT_LOGIC - arith encoding for a logical shift
//   SHIFT_ARITH - arith encoding for an arithmetic (sign-fill) shift
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_LEFT    = 1'b0;
    localparam logic DIR_RIGHT   = 1'b1;
    localparam logic SHIFT_LOGIC = 1'b0;
    localparam logic SHIFT_ARITH = 1'b1;

endpackage

// File: rtl/shift_one_step.sv
// Combinational single-position shifter reused every cycle by the sequencer.
// Ports:
//   data    - value to shift (N bits)
//   dir     - DIR_LEFT / DIR_RIGHT
//   arith   - SHIFT_ARITH fills with the sign bit on a right shift
//   shifted - data shifted by exactly one position
//   out_bit - the bit that falls off the end
module shift_one_step
    import shift_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] data,
    input  logic         dir,
    input  logic         arith,
    output logic [N-1:0] shifted,
    output logic         out_bit
);

    // Left shifts always fill with zero; arith only matters for right
    // shifts, where it chooses between zero fill and sign replication.
    always_comb begin
        shifted = '0;
        out_bit = 1'b0;
        if (dir == DIR_LEFT) begin
            shifted = {data[N-2:0], 1'b0};
            out_bit = data[N-1];
        end else begin
            shifted = {((arith == SHIFT_ARITH) ? data[N-1] : 1'b0), data[N-1:1]};
            out_bit = data[0];
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift unit: captures an operand and shift amount, then applies
// one single-position shift per clock through shift_one_step.
// Ports:
//   clk, rst  - rising-edge clock, synchronous active-high reset
//   start     - request pulse, only looked at while idle
//   data_in   - operand (N bits), captured on accepted start
//   shamt     - shift amount (SHW bits), clamped to N
//   dir       - 0 left, 1 right
//   arith     - 1 arithmetic, 0 logical
//   busy      - high whenever the FSM is not idle
//   done      - one-cycle pulse, result valid
//   data_out  - shifted result, held until the next done
//   carry_out - last bit shifted out
//   zero      - data_out == 0
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int N   = 8,
    parameter int SHW = $clog2(N) + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   data_in,
    input  logic [SHW-1:0] shamt,
    input  logic           dir,
    input  logic           arith,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   data_out,
    output logic           carry_out,
    output logic           zero
);

    state_t         state;
    logic [N-1:0]   work;
    logic           dir_q;
    logic           arith_q;
    logic [SHW-1:0] count;
    logic [SHW-1:0] shamt_eff;
    logic [N-1:0]   step_data;
    logic           step_bit;

    // Anything beyond N shifts gives the same result as N shifts, so the
    // amount is clamped before it ever reaches the counter.
    assign shamt_eff = (shamt > SHW'(N)) ? SHW'(N) : shamt;

    shift_one_step #(.N(N)) u_step (
        .data    (work),
        .dir     (dir_q),
        .arith   (arith_q),
        .shifted (step_data),
        .out_bit (step_bit)
    );

    // The result registers are only written on the edge that enters DONE,
    // so the previous result stays visible while a new operation runs.
    // carry_out therefore takes the bit from the final shift step only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            data_out  <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b1;
            count     <= '0;
            work      <= '0;
            dir_q     <= DIR_LEFT;
            arith_q   <= SHIFT_LOGIC;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        work    <= data_in;
                        dir_q   <= dir;
                        arith_q <= arith;
                        count   <= shamt_eff;
                        busy    <= 1'b1;
                        if (shamt_eff == '0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            data_out  <= data_in;
                            carry_out <= 1'b0;
                            zero      <= (data_in == '0);
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work  <= step_data;
                    count <= count - SHW'(1);
                    if (count == SHW'(1)) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        data_out  <= step_data;
                        carry_out <= step_bit;
                        zero      <= (step_data == '0);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed testbench for shift_sequencer (N = 8) with hand-computed results.
module tb_shift_sequencer;

    localparam int N   = 8;
    localparam int SHW = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   data_in;
    logic [SHW-1:0] shamt;
    logic           dir;
    logic           arith;
    logic           busy;
    logic           done;
    logic [N-1:0]   data_out;
    logic           carry_out;
    logic           zero;

    int             testCount;
    int             failCount;
    string          testName;
    logic [N-1:0]   prevData;

    shift_sequencer #(.N(N), .SHW(SHW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .data_in   (data_in),
        .shamt     (shamt),
        .dir       (dir),
        .arith     (arith),
        .busy      (busy),
        .done      (done),
        .data_out  (data_out),
        .carry_out (carry_out),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s/%s: got %0h, expected %0h", testName, tag, actual, expected);
        end
    endtask

    // Issues one request and walks its lifetime cycle by cycle. lat is the
    // expected done cycle relative to the accepting edge. injectCycle > 0
    // pulses a conflicting start (data 8'hFF) during that busy cycle.
    task automatic applyStimulus(input string name, input logic [N-1:0] d,
                                 input logic [SHW-1:0] s, input logic dr,
                                 input logic ar, input int lat,
                                 input logic [N-1:0] expData,
                                 input logic expCarry, input int injectCycle);
        testName = name;
        @(negedge clk);
        data_in = d;
        shamt   = s;
        dir     = dr;
        arith   = ar;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            checkOutput($sformatf("busy@%0d", c), 32'(busy), 32'd1);
            checkOutput($sformatf("done@%0d", c), 32'(done), 32'(c == lat));
            if (c < lat) begin
                checkOutput($sformatf("hold@%0d", c), 32'(data_out), 32'(prevData));
            end else begin
                checkOutput("data_out", 32'(data_out), 32'(expData));
                checkOutput("carry_out", 32'(carry_out), 32'(expCarry));
                checkOutput("zero", 32'(zero), 32'(expData == '0));
            end
            if (c == injectCycle) begin
                start   = 1'b1;
                data_in = 8'hFF;
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("busy_after", 32'(busy), 32'd0);
        checkOutput("done_after", 32'(done), 32'd0);
        prevData = expData;
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        prevData  = '0;
        testName  = "reset";
        rst     = 1'b1;
        start   = 1'b1;
        data_in = 8'h33;
        shamt   = 4'd1;
        dir     = 1'b0;
        arith   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("busy", 32'(busy), 32'd0);
        checkOutput("done", 32'(done), 32'd0);
        checkOutput("data_out", 32'(data_out), 32'd0);
        checkOutput("carry_out", 32'(carry_out), 32'd0);
        checkOutput("zero", 32'(zero), 32'd1);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;

        applyStimulus("left3",      8'h96, 4'd3,  1'b0, 1'b0, 4, 8'hB0, 1'b0, 0);
        applyStimulus("rarith2",    8'h96, 4'd2,  1'b1, 1'b1, 3, 8'hE5, 1'b1, 0);
        applyStimulus("rlogic9",    8'h96, 4'd9,  1'b1, 1'b0, 9, 8'h00, 1'b1, 0);
        applyStimulus("shamt0",     8'h5A, 4'd0,  1'b0, 1'b0, 1, 8'h5A, 1'b0, 0);
        applyStimulus("rarith12",   8'h96, 4'd12, 1'b1, 1'b1, 9, 8'hFF, 1'b1, 0);
        applyStimulus("left8",      8'h01, 4'd8,  1'b0, 1'b1, 9, 8'h00, 1'b1, 0);
        applyStimulus("rlogic1",    8'h81, 4'd1,  1'b1, 1'b0, 2, 8'h40, 1'b1, 0);
        applyStimulus("busyignore", 8'h96, 4'd4,  1'b0, 1'b0, 5, 8'h60, 1'b1, 2);

        // Reset in the middle of a 5-step shift: aborted, no done pulse.
        testName = "midreset";
        @(negedge clk);
        data_in = 8'h96;
        shamt   = 4'd5;
        dir     = 1'b0;
        arith   = 1'b0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy_k1", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("busy_k3", 32'(busy), 32'd0);
        checkOutput("done_k3", 32'(done), 32'd0);
        checkOutput("data_k3", 32'(data_out), 32'd0);
        checkOutput("carry_k3", 32'(carry_out), 32'd0);
        checkOutput("zero_k3", 32'(zero), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("nodone%0d", i), 32'(done), 32'd0);
            checkOutput($sformatf("idle%0d", i), 32'(busy), 32'd0);
        end
        prevData = '0;

        applyStimulus("afterreset", 8'h96, 4'd3, 1'b0, 1'b0, 4, 8'hB0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
